data_demux_rx: RTL
==================

Name: data_demux_rx

Overview:
- Receive-side counterpart of the link transmit mux.
- Takes one serialized AXIS word stream and undoes the optional bit reversal.
- Classifies each word as idle, idle-BX0, header, header-BX0 or bad. Tracks word lock with a state machine, strips idles and header bits, and routes payload words to one of N_OUTPUTS AXIS streams.
- Exposes lock status, BX0 period and error/idle counters for the control interface.

Parameters:
DATA_WIDTH, 32, word width in bits
N_OUTPUTS, 16, number of output AXIS streams; at most 16 (output_select is 4 bits)
INPUT_REVERSE_BITS, 1, 1 = bit-reverse the input word before any processing
LOCK_COUNT, 8, consecutive good words needed to enter LOCKED (range 1..255)
UNLOCK_COUNT, 4, consecutive bad words in LOCKED that force UNLOCKED (range 1..255)

Ports:
clk  in  1  single clock
rstn  in  1  asynchronous active-low reset
tdata_in  in  DATA_WIDTH  input stream data
tvalid_in  in  1  input stream valid
tready_in  out  1  input stream ready
tdata_out  out  DATA_WIDTH x N_OUTPUTS  output stream data (unpacked array)
tvalid_out  out  1 x N_OUTPUTS  output stream valid
tready_out  in  1 x N_OUTPUTS  output stream ready
output_select  in  4  index of the active output stream
idle_word, idle_word_BX0, header_mask, header, header_BX0  in  DATA_WIDTH each  link format configuration
clear_counters  in  1  synchronous clear of idle_count, header_err_count and bx0_period
locked  out  1  high in LOCKED state
bx0_seen  out  1  one-cycle pulse on an accepted BX0 word
idle_count  out  16  idle words accepted (saturating)
header_err_count  out  16  bad words accepted while LOCKED (saturating)
bx0_period  out  16  accepted words between the last two BX0 words (saturating)

Behaviour:
- Reset (rstn low, asynchronous):
  - all tvalid_out = 0, tdata_out = 0, locked = 0, bx0_seen = 0;
  - all counters = 0, FSM = UNLOCKED, pipeline valids = 0.
- Handshake and stalls:
  - "adv" = tready_out[output_select].
  - tready_in = adv; no pipeline stage changes state unless adv = 1.
  - An input word is accepted on tvalid_in & tready_in.
  - output_select >= N_OUTPUTS: adv is forced to 1 and no payload is presented on any output (words are dropped).
- Stage 1 (register, on accept):
  - word_r = tdata_in, bit-reversed when INPUT_REVERSE_BITS = 1 (bit i = tdata_in[DATA_WIDTH-1-i]).
  - valid_r = tvalid_in.
- Classification (combinational on word_r), in priority order:
  1. IDLE_BX0: word == idle_word_BX0.
  2. IDLE: word == idle_word.
  3. HDR_BX0: (word & header_mask) == (header_BX0 & header_mask).
  4. HDR: (word & header_mask) == (header & header_mask).
  5. BAD: anything else.
- Lock FSM (updates only for valid_r & adv); good = class != BAD:
  - UNLOCKED: good -> LOCKING, good_cnt = 1. With LOCK_COUNT = 1, go straight to LOCKED.
  - LOCKING: good -> good_cnt+1; when good_cnt+1 == LOCK_COUNT -> LOCKED. BAD -> UNLOCKED, good_cnt = 0.
  - LOCKED: good -> bad_cnt = 0. BAD -> bad_cnt+1 and header_err_count+1; when bad_cnt+1 == UNLOCK_COUNT -> UNLOCKED.
  - locked output is registered from the FSM state.
- Stage 2 / output:
  - Only HDR or HDR_BX0 words classified while the FSM is LOCKED (state before this word's update) are forwarded.
  - Forwarded data = word_r & ~header_mask, presented on tdata_out[output_select] with tvalid_out[output_select] = 1.
  - All other outputs: tvalid_out = 0, data held.
  - If adv = 0, the output register holds.
  - Latency: 2 cycles from input accept to tvalid_out.
  - Idle and BAD words are never forwarded.
- Counters (only on valid_r & adv):
  - idle_count +1 on IDLE or IDLE_BX0, in any FSM state.
  - Internal since_bx0 +1 per accepted word.
  - On IDLE_BX0 or HDR_BX0: bx0_period <= since_bx0 + 1 (saturating), since_bx0 <= 0, bx0_seen pulses for one cycle.
  - All counters saturate at 16'hFFFF; no wrap.
  - clear_counters has priority over increment in the same cycle; it does not affect the FSM.
- Edge cases:
  - output_select changes mid-stream: takes effect on the next stage-2 load. A word already held on the old output stays valid there until that output's tready is seen, then it drops.
  - Config changes apply to the next classified word.

Decomposition:
- Package data_mux_pkg:
  - word_class_t enum {IDLE, IDLE_BX0, HDR, HDR_BX0, BAD};
  - lock_state_t enum {UNLOCKED, LOCKING, LOCKED};
  - localparam CNT_W = 16.
- Sub-module data_word_classifier: purely combinational; inputs word plus the five config words; output word_class_t.

Test Plan:
- Acquire lock, LOCK_COUNT = 8: 7 HDR words -> locked = 0; 8th -> locked = 1 two cycles later; 9th HDR 0xA5000123 with header_mask 0xFF000000 -> tdata_out[sel] = 0x00000123.
- Lose lock, UNLOCK_COUNT = 4: in LOCKED, 3 BAD, 1 HDR, 4 BAD -> stays locked after the first burst, unlocks after the fourth BAD of the second burst, header_err_count = 7.
- Idle and BX0 stripping: IDLE, IDLE, IDLE_BX0, 10 HDR, HDR_BX0 -> no output for the idles, idle_count = 3, bx0_period = 11, bx0_seen pulses twice.
- Backpressure: tready_out[sel] = 0 for 5 cycles mid-stream -> tready_in = 0, tdata_out and tvalid_out held, no words lost or duplicated; scoreboard matches.
- Bit reversal, INPUT_REVERSE_BITS = 1: input 0x00000001 with header 0x80000000, header_mask 0x80000000 -> classified HDR; the reversed word 0x80000000 is masked to payload 0x00000000.
- Reset mid-operation: assert rstn low while LOCKED with counters nonzero -> locked, tvalid_out and all counters are 0 immediately (asynchronous), and lock requires LOCK_COUNT good words again.

Source files
------------

// File: rtl/data_mux_pkg.sv
// -----------------------------------------------------------------------------
// data_mux_pkg
// Shared types for the link receive demux: the word classes produced by the
// classifier, the lock state machine encoding, the counter width and a
// saturating increment used by every status counter.
// No ports (package).
// -----------------------------------------------------------------------------
package data_mux_pkg;

  typedef enum logic [2:0] {
    IDLE,
    IDLE_BX0,
    HDR,
    HDR_BX0,
    BAD
  } word_class_t;

  typedef enum logic [1:0] {
    UNLOCKED,
    LOCKING,
    LOCKED
  } lock_state_t;

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  // Status counters stick at all-ones instead of wrapping, so software can
  // tell a very large count from a small one.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    return (value == CNT_MAX) ? value : value + CNT_ONE;
  endfunction

endpackage

// File: rtl/data_demux_rx_if.sv
// -----------------------------------------------------------------------------
// data_demux_rx_if
// Bundles the AXIS-style streams of the receive demux: one serialized input
// stream and N_OUTPUTS payload output streams.
//   tdata_in/tvalid_in/tready_in    : input stream
//   tdata_out/tvalid_out/tready_out : output streams (data is an unpacked array)
// Modports:
//   master : the environment side (drives the input word, consumes outputs)
//   slave  : the demux itself
// -----------------------------------------------------------------------------
interface data_demux_rx_if #(
  parameter int DATA_WIDTH = 32,
  parameter int N_OUTPUTS  = 16
) ();

  logic [DATA_WIDTH-1:0] tdata_in;
  logic                  tvalid_in;
  logic                  tready_in;
  logic [DATA_WIDTH-1:0] tdata_out [N_OUTPUTS];
  logic [N_OUTPUTS-1:0]  tvalid_out;
  logic [N_OUTPUTS-1:0]  tready_out;

  modport master (
    output tdata_in,
    output tvalid_in,
    input  tready_in,
    input  tdata_out,
    input  tvalid_out,
    output tready_out
  );

  modport slave (
    input  tdata_in,
    input  tvalid_in,
    output tready_in,
    output tdata_out,
    output tvalid_out,
    input  tready_out
  );

endinterface

// File: rtl/data_word_classifier.sv
// -----------------------------------------------------------------------------
// data_word_classifier
// Purely combinational classification of one link word against the link
// format configuration.
//   word_i          : word to classify (already bit-order corrected)
//   idle_word_i     : plain idle pattern (exact match)
//   idle_word_bx0_i : idle pattern carrying BX0 (exact match)
//   header_mask_i   : bits that hold the header field
//   header_i        : header pattern (compared under the mask)
//   header_bx0_i    : header pattern carrying BX0 (compared under the mask)
//   class_o         : resulting word class
// -----------------------------------------------------------------------------
module data_word_classifier
  import data_mux_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] word_i,
  input  logic [DATA_WIDTH-1:0] idle_word_i,
  input  logic [DATA_WIDTH-1:0] idle_word_bx0_i,
  input  logic [DATA_WIDTH-1:0] header_mask_i,
  input  logic [DATA_WIDTH-1:0] header_i,
  input  logic [DATA_WIDTH-1:0] header_bx0_i,
  output word_class_t           class_o
);

  logic [DATA_WIDTH-1:0] maskedWord;

  assign maskedWord = word_i & header_mask_i;

  // Idles are exact matches and win over headers, so an idle whose top bits
  // happen to look like a header is still treated as an idle. BX0 variants
  // are checked before their plain counterparts.
  always_comb begin
    class_o = BAD;
    if (word_i == idle_word_bx0_i) begin
      class_o = IDLE_BX0;
    end else if (word_i == idle_word_i) begin
      class_o = IDLE;
    end else if (maskedWord == (header_bx0_i & header_mask_i)) begin
      class_o = HDR_BX0;
    end else if (maskedWord == (header_i & header_mask_i)) begin
      class_o = HDR;
    end
  end

endmodule

// File: rtl/data_demux_rx.sv
// -----------------------------------------------------------------------------
// data_demux_rx
// Receive side of the link mux. Takes one serialized word stream, optionally
// bit-reverses it, classifies each word, tracks word lock, strips idles and
// header bits and routes payload words to one of N_OUTPUTS output streams.
//   clk, rstn          : clock and asynchronous active-low reset
//   link (slave)       : input stream and output stream array
//   output_select      : index of the output stream receiving payload
//   idle_word, idle_word_BX0, header_mask, header, header_BX0 : link format
//   clear_counters     : synchronous clear of the status counters
//   locked             : high while the lock FSM is LOCKED
//   bx0_seen           : one-cycle pulse per accepted BX0 word
//   idle_count         : idle words accepted (saturating)
//   header_err_count   : bad words accepted while LOCKED (saturating)
//   bx0_period         : accepted words between the last two BX0s (saturating)
// -----------------------------------------------------------------------------
module data_demux_rx
  import data_mux_pkg::*;
#(
  parameter int DATA_WIDTH         = 32,
  parameter int N_OUTPUTS          = 16,
  parameter int INPUT_REVERSE_BITS = 1,
  parameter int LOCK_COUNT         = 8,
  parameter int UNLOCK_COUNT       = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  data_demux_rx_if.slave        link,
  input  logic [3:0]            output_select,
  input  logic [DATA_WIDTH-1:0] idle_word,
  input  logic [DATA_WIDTH-1:0] idle_word_BX0,
  input  logic [DATA_WIDTH-1:0] header_mask,
  input  logic [DATA_WIDTH-1:0] header,
  input  logic [DATA_WIDTH-1:0] header_BX0,
  input  logic                  clear_counters,
  output logic                  locked,
  output logic                  bx0_seen,
  output logic [CNT_W-1:0]      idle_count,
  output logic [CNT_W-1:0]      header_err_count,
  output logic [CNT_W-1:0]      bx0_period
);

  localparam logic [7:0] LOCK_CNT   = 8'(LOCK_COUNT);
  localparam logic [7:0] UNLOCK_CNT = 8'(UNLOCK_COUNT);

  logic                  adv;
  logic [DATA_WIDTH-1:0] inWord;
  logic [DATA_WIDTH-1:0] word_q;
  logic                  valid_q;
  word_class_t           wordClass;
  logic                  process;
  logic                  isGood;
  logic                  isIdle;
  logic                  isBx0;
  logic                  isHeader;
  logic                  fwd;
  logic                  hdrErr;
  logic [DATA_WIDTH-1:0] payload;

  lock_state_t           state_q;
  logic [7:0]            good_cnt_q;
  logic [7:0]            bad_cnt_q;
  logic                  locked_q;

  logic [CNT_W-1:0]      idle_count_q;
  logic [CNT_W-1:0]      hdr_err_q;
  logic [CNT_W-1:0]      bx0_period_q;
  logic [CNT_W-1:0]      since_bx0_q;
  logic                  bx0_seen_q;

  logic [DATA_WIDTH-1:0] tdata_q [N_OUTPUTS];
  logic [N_OUTPUTS-1:0]  tvalid_q;

  // The whole pipeline advances on the ready of the selected output. A select
  // beyond the implemented outputs never stalls: words keep flowing and are
  // simply not presented anywhere.
  always_comb begin
    adv = 1'b1;
    for (int i = 0; i < N_OUTPUTS; i++) begin
      if (output_select == 4'(i)) begin
        adv = link.tready_out[i];
      end
    end
  end

  assign link.tready_in = adv;

  // Bit-order correction is pure wiring chosen at elaboration time.
  generate
    if (INPUT_REVERSE_BITS != 0) begin : g_reverse
      for (genvar g = 0; g < DATA_WIDTH; g++) begin : g_bit
        assign inWord[g] = link.tdata_in[DATA_WIDTH-1-g];
      end
    end else begin : g_straight
      assign inWord = link.tdata_in;
    end
  endgenerate

  // Stage 1 captures the corrected word; data only changes on a real accept
  // so a bubble leaves the last word in place.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      word_q  <= '0;
      valid_q <= 1'b0;
    end else if (adv) begin
      valid_q <= link.tvalid_in;
      if (link.tvalid_in) begin
        word_q <= inWord;
      end
    end
  end

  data_word_classifier #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_classifier (
    .word_i          (word_q),
    .idle_word_i     (idle_word),
    .idle_word_bx0_i (idle_word_BX0),
    .header_mask_i   (header_mask),
    .header_i        (header),
    .header_bx0_i    (header_BX0),
    .class_o         (wordClass)
  );

  // A stage-1 word is consumed only when the pipeline advances; all state
  // below keys off this single qualifier.
  assign process  = valid_q & adv;
  assign isGood   = (wordClass != BAD);
  assign isIdle   = (wordClass == IDLE) || (wordClass == IDLE_BX0);
  assign isBx0    = (wordClass == IDLE_BX0) || (wordClass == HDR_BX0);
  assign isHeader = (wordClass == HDR) || (wordClass == HDR_BX0);
  assign fwd      = process && (state_q == LOCKED) && isHeader;
  assign hdrErr   = process && (state_q == LOCKED) && (wordClass == BAD);
  assign payload  = word_q & ~header_mask;

  // Lock tracking: a run of good words brings the link up, a run of bad
  // words while up takes it down. Forwarding uses the state before the
  // current word updates it, so the word that completes lock is not itself
  // forwarded. locked is produced here alongside the state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= UNLOCKED;
      good_cnt_q <= '0;
      bad_cnt_q  <= '0;
      locked_q   <= 1'b0;
    end else if (process) begin
      case (state_q)
        UNLOCKED: begin
          if (isGood) begin
            bad_cnt_q <= '0;
            if (LOCK_CNT == 8'd1) begin
              state_q    <= LOCKED;
              good_cnt_q <= '0;
              locked_q   <= 1'b1;
            end else begin
              state_q    <= LOCKING;
              good_cnt_q <= 8'd1;
            end
          end
        end
        LOCKING: begin
          if (isGood) begin
            if (good_cnt_q + 8'd1 == LOCK_CNT) begin
              state_q    <= LOCKED;
              good_cnt_q <= '0;
              bad_cnt_q  <= '0;
              locked_q   <= 1'b1;
            end else begin
              good_cnt_q <= good_cnt_q + 8'd1;
            end
          end else begin
            state_q    <= UNLOCKED;
            good_cnt_q <= '0;
          end
        end
        LOCKED: begin
          if (isGood) begin
            bad_cnt_q <= '0;
          end else if (bad_cnt_q + 8'd1 == UNLOCK_CNT) begin
            state_q    <= UNLOCKED;
            bad_cnt_q  <= '0;
            good_cnt_q <= '0;
            locked_q   <= 1'b0;
          end else begin
            bad_cnt_q <= bad_cnt_q + 8'd1;
          end
        end
        default: begin
          state_q    <= UNLOCKED;
          good_cnt_q <= '0;
          bad_cnt_q  <= '0;
          locked_q   <= 1'b0;
        end
      endcase
    end
  end

  // Status counters. A clear wins over an increment in the same cycle. The
  // running distance to the last BX0 is internal bookkeeping and is not
  // touched by the clear, so the next period measurement stays correct.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      idle_count_q <= '0;
      hdr_err_q    <= '0;
      bx0_period_q <= '0;
      since_bx0_q  <= '0;
      bx0_seen_q   <= 1'b0;
    end else begin
      if (clear_counters) begin
        idle_count_q <= '0;
        hdr_err_q    <= '0;
        bx0_period_q <= '0;
      end else if (process) begin
        if (isIdle) begin
          idle_count_q <= sat_inc(idle_count_q);
        end
        if (hdrErr) begin
          hdr_err_q <= sat_inc(hdr_err_q);
        end
        if (isBx0) begin
          bx0_period_q <= sat_inc(since_bx0_q);
        end
      end
      if (process) begin
        since_bx0_q <= isBx0 ? '0 : sat_inc(since_bx0_q);
      end
      bx0_seen_q <= process & isBx0;
    end
  end

  // Stage 2 output registers. The selected output loads (or drops valid)
  // whenever the pipeline advances. Any other output still holding a word,
  // e.g. after output_select moved, keeps it until its own ready is seen.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < N_OUTPUTS; i++) begin
        tdata_q[i] <= '0;
      end
      tvalid_q <= '0;
    end else begin
      for (int i = 0; i < N_OUTPUTS; i++) begin
        if (output_select == 4'(i)) begin
          if (adv) begin
            tvalid_q[i] <= fwd;
            if (fwd) begin
              tdata_q[i] <= payload;
            end
          end
        end else if (link.tready_out[i]) begin
          tvalid_q[i] <= 1'b0;
        end
      end
    end
  end

  assign link.tdata_out  = tdata_q;
  assign link.tvalid_out = tvalid_q;

  assign locked           = locked_q;
  assign bx0_seen         = bx0_seen_q;
  assign idle_count       = idle_count_q;
  assign header_err_count = hdr_err_q;
  assign bx0_period       = bx0_period_q;

endmodule
